// File: rtl/alu_2_if.sv
// Operand, control and result bundle for alu_2. The datapath side uses the master modport
// and the ALU uses the slave modport.
interface alu_2_if;
   logic               en;
   logic [63:0]        rs1;
   logic [63:0]        rs2;
   logic [3:0]         ALUControl;
   logic signed [63:0] rd;
   logic               zero;
   logic [63:0]        rd_q;
   logic               zero_q;
   logic               carry_q;
   logic               overflow_q;

   modport master (
      output en, rs1, rs2, ALUControl,
      input  rd, zero, rd_q, zero_q, carry_q, overflow_q
   );

   modport slave (
      input  en, rs1, rs2, ALUControl,
      output rd, zero, rd_q, zero_q, carry_q, overflow_q
   );
endinterface

// File: rtl/alu_2.sv
// 64-bit RISC-V ALU: a zero-latency combinational result plus a registered result with flags.
// Defining ALU_MUL_EN enables opcode 4'b1010 (low 64 bits of rs1 * rs2).
module alu_2 (
   input logic    clk,
   input logic    reset,
   alu_2_if.slave alu
);

   typedef enum logic [3:0] {
      OpAnd  = 4'b0000,
      OpOr   = 4'b0001,
      OpAdd  = 4'b0010,
      OpXor  = 4'b0011,
      OpSll  = 4'b0100,
      OpSrl  = 4'b0101,
      OpSub  = 4'b0110,
      OpSlt  = 4'b0111,
      OpSltu = 4'b1000,
      OpSra  = 4'b1001,
      OpMul  = 4'b1010
   } alu_op_e;

   logic [63:0] a;
   logic [63:0] b;
   logic [5:0]  shamt;
   logic [64:0] add_w;
   logic [63:0] sub_r;
   logic [63:0] res;
   logic        res_zero;
   logic        carry;
   logic        ovf;

   logic [63:0] rd_d, rd_q;
   logic        zero_d, zero_q;
   logic        carry_d, carry_q;
   logic        ovf_d, ovf_q;

   assign a     = alu.rs1;
   assign b     = alu.rs2;
   assign shamt = b[5:0];

   always_comb begin
      res   = '0;
      carry = 1'b0;
      ovf   = 1'b0;
      add_w = {1'b0, a} + {1'b0, b};
      sub_r = a - b;
      case (alu.ALUControl)
         OpAnd:  res = a & b;
         OpOr:   res = a | b;
         OpXor:  res = a ^ b;
         OpAdd: begin
            res   = add_w[63:0];
            carry = add_w[64];
            ovf   = (a[63] == b[63]) && (add_w[63] != a[63]);
         end
         OpSub: begin
            res   = sub_r;
            carry = (a >= b);
            ovf   = (a[63] != b[63]) && (sub_r[63] != a[63]);
         end
         OpSll:  res = a << shamt;
         OpSrl:  res = a >> shamt;
         OpSra:  res = $signed(a) >>> shamt;
         OpSlt:  res = ($signed(a) < $signed(b)) ? 64'd1 : 64'd0;
         OpSltu: res = (a < b) ? 64'd1 : 64'd0;
`ifdef ALU_MUL_EN
         OpMul:  res = a * b;
`else
         OpMul:  res = '0;
`endif
         default: res = '0;
      endcase
   end

   assign res_zero = (res == 64'd0);
   assign alu.rd   = res;
   assign alu.zero = res_zero;

   always_comb begin
      rd_d    = rd_q;
      zero_d  = zero_q;
      carry_d = carry_q;
      ovf_d   = ovf_q;
      if (alu.en) begin
         rd_d    = res;
         zero_d  = res_zero;
         carry_d = carry;
         ovf_d   = ovf;
      end
   end

   // Reset wins over en; no power-up value is assumed.
   always_ff @(posedge clk) begin
      if (reset) begin
         rd_q    <= '0;
         zero_q  <= 1'b1;
         carry_q <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         rd_q    <= rd_d;
         zero_q  <= zero_d;
         carry_q <= carry_d;
         ovf_q   <= ovf_d;
      end
   end

   assign alu.rd_q       = rd_q;
   assign alu.zero_q     = zero_q;
   assign alu.carry_q    = carry_q;
   assign alu.overflow_q = ovf_q;

endmodule

// File: tb/tb_alu_2.sv
// Bench for alu_2: directed cases from the plan, then random ops against an arithmetic model.
module tb_alu_2;

   logic clk = 1'b0;
   logic reset;
   int   n_checks = 0;
   int   n_bad = 0;

   alu_2_if bus ();

   alu_2 u_dut (
      .clk   (clk),
      .reset (reset),
      .alu   (bus)
   );

   always #5 clk = ~clk;

   localparam logic signed [127:0] SMax = 128'sh7FFF_FFFF_FFFF_FFFF;
   localparam logic signed [127:0] SMin = -128'sh8000_0000_0000_0000;

   task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Reference built from wide signed/unsigned arithmetic rather than bit tricks.
   function automatic void model(input logic [3:0] op, input logic [63:0] a,
                                 input logic [63:0] b, output logic [63:0] r,
                                 output logic c, output logic v);
      logic signed [127:0] sa, sb, st;
      logic [64:0] w;
      int n;
      sa = {{64{a[63]}}, a};
      sb = {{64{b[63]}}, b};
      n  = int'(b[5:0]);
      r = '0; c = 1'b0; v = 1'b0;
      case (op)
         4'd0: r = a & b;
         4'd1: r = a | b;
         4'd2: begin
            w = {1'b0, a} + {1'b0, b};
            r = w[63:0]; c = w[64];
            st = sa + sb; v = (st > SMax) || (st < SMin);
         end
         4'd3: r = a ^ b;
         4'd4: r = a << n;
         4'd5: r = a >> n;
         4'd6: begin
            r = a - b; c = (a >= b);
            st = sa - sb; v = (st > SMax) || (st < SMin);
         end
         4'd7: r = (sa < sb) ? 64'd1 : 64'd0;
         4'd8: r = (a < b) ? 64'd1 : 64'd0;
         4'd9: r = (a >> n) | (a[63] ? ~(64'hFFFF_FFFF_FFFF_FFFF >> n) : 64'd0);
`ifdef ALU_MUL_EN
         4'd10: r = a * b;
`endif
         default: r = '0;
      endcase
   endfunction

   task automatic drive(input logic [3:0] op, input logic [63:0] a, input logic [63:0] b,
                        input logic e);
      @(negedge clk);
      bus.ALUControl = op;
      bus.rs1 = a;
      bus.rs2 = b;
      bus.en = e;
      #1;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [63:0] pick();
      case ($urandom_range(0, 7))
         0: return 64'd0;
         1: return 64'hFFFF_FFFF_FFFF_FFFF;
         2: return 64'h7FFF_FFFF_FFFF_FFFF;
         3: return 64'h8000_0000_0000_0000;
         4: return 64'($urandom_range(0, 70));
         default: return {$urandom, $urandom};
      endcase
   endfunction

   logic [63:0] m_r, e_rd;
   logic        m_c, m_v, e_z, e_c, e_v;

   initial begin
      reset = 1'b1;
      bus.en = 1'b0;
      bus.ALUControl = 4'd0;
      bus.rs1 = '0;
      bus.rs2 = '0;
      tick();
      check_val("reset_rd_q", bus.rd_q, 64'd0);
      check_val("reset_zero_q", 64'(bus.zero_q), 64'd1);
      check_val("reset_carry_q", 64'(bus.carry_q), 64'd0);
      check_val("reset_ovf_q", 64'(bus.overflow_q), 64'd0);
      reset = 1'b0;

      drive(4'b0010, 64'h1C, 64'd4, 1'b0);
      check_val("pc_inc_rd", bus.rd, 64'h20);
      check_val("pc_inc_zero", 64'(bus.zero), 64'd0);

      drive(4'b0010, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b1);
      check_val("wrap_rd", bus.rd, 64'd0);
      tick();
      check_val("wrap_rd_q", bus.rd_q, 64'd0);
      check_val("wrap_zero_q", 64'(bus.zero_q), 64'd1);
      check_val("wrap_carry_q", 64'(bus.carry_q), 64'd1);
      check_val("wrap_ovf_q", 64'(bus.overflow_q), 64'd0);

      drive(4'b0010, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b1);
      tick();
      check_val("add_ovf_q", 64'(bus.overflow_q), 64'd1);
      check_val("add_ovf_carry_q", 64'(bus.carry_q), 64'd0);

      drive(4'b0110, 64'd5, 64'd7, 1'b1);
      check_val("sub_rd", bus.rd, 64'hFFFF_FFFF_FFFF_FFFE);
      tick();
      check_val("sub_carry_q", 64'(bus.carry_q), 64'd0);
      drive(4'b0110, 64'd7, 64'd5, 1'b1);
      tick();
      check_val("sub_nb_carry_q", 64'(bus.carry_q), 64'd1);

      drive(4'b0111, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0);
      check_val("slt_rd", bus.rd, 64'd1);
      drive(4'b1000, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0);
      check_val("sltu_rd", bus.rd, 64'd0);

      drive(4'b0101, 64'h8000_0000_0000_0000, 64'h43, 1'b0);
      check_val("srl_rd", bus.rd, 64'h1000_0000_0000_0000);
      drive(4'b1001, 64'h8000_0000_0000_0000, 64'h43, 1'b0);
      check_val("sra_rd", bus.rd, 64'hF000_0000_0000_0000);
      drive(4'b0100, 64'd1, 64'd63, 1'b0);
      check_val("sll63_rd", bus.rd, 64'h8000_0000_0000_0000);
      drive(4'b0100, 64'h1234_5678_9ABC_DEF0, 64'h40, 1'b0);
      check_val("sll0_rd", bus.rd, 64'h1234_5678_9ABC_DEF0);

      drive(4'b0010, 64'd3, 64'd4, 1'b1);
      tick();
      check_val("load_rd_q", bus.rd_q, 64'd7);
      for (int i = 0; i < 3; i++) begin
         drive(4'b0001, 64'(i + 100), 64'h55, 1'b0);
         tick();
         check_val("hold_rd_q", bus.rd_q, 64'd7);
         check_val("hold_zero_q", 64'(bus.zero_q), 64'd0);
      end

      drive(4'b0010, 64'd1, 64'd2, 1'b1);
      reset = 1'b1;
      check_val("rst_comb_rd", bus.rd, 64'd3);
      tick();
      check_val("rst_rd_q", bus.rd_q, 64'd0);
      check_val("rst_zero_q", 64'(bus.zero_q), 64'd1);
      check_val("rst_comb_rd_after", bus.rd, 64'd3);
      reset = 1'b0;

      drive(4'b1010, 64'd6, 64'd7, 1'b0);
`ifdef ALU_MUL_EN
      check_val("mul_rd", bus.rd, 64'd42);
`else
      check_val("mul_off_rd", bus.rd, 64'd0);
`endif
      drive(4'b1111, 64'd6, 64'd7, 1'b0);
      check_val("resv_rd", bus.rd, 64'd0);
      check_val("resv_zero", 64'(bus.zero), 64'd1);

      // Random phase; first iteration forces reset so the register model starts known.
      for (int i = 0; i < 400; i++) begin
         drive(4'($urandom_range(0, 15)), pick(), pick(), 1'($urandom_range(0, 3) != 0));
         reset = (i == 0) || ($urandom_range(0, 15) == 0);
         model(bus.ALUControl, bus.rs1, bus.rs2, m_r, m_c, m_v);
         check_val("rnd_rd", bus.rd, m_r);
         check_val("rnd_zero", 64'(bus.zero), 64'(m_r == 64'd0));
         if (reset) begin
            e_rd = '0; e_z = 1'b1; e_c = 1'b0; e_v = 1'b0;
         end else if (bus.en) begin
            e_rd = m_r; e_z = (m_r == 64'd0); e_c = m_c; e_v = m_v;
         end
         tick();
         check_val("rnd_rd_q", bus.rd_q, e_rd);
         check_val("rnd_zero_q", 64'(bus.zero_q), 64'(e_z));
         check_val("rnd_carry_q", 64'(bus.carry_q), 64'(e_c));
         check_val("rnd_ovf_q", 64'(bus.overflow_q), 64'(e_v));
         reset = 1'b0;
      end

      $display("test done: total=%0d bad=%0d", n_checks, n_bad);
      $finish;
   end

endmodule
